// File: rtl/elbeth_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : elbeth_fetch_unit_if
// Brief    : Bundles the fetch unit's redirect, decode-stall, instruction
//            memory and IF/ID pipeline register signals.
// Revision : 1.0 - initial release
// ============================================================================
interface elbeth_fetch_unit_if;
  // Redirect from the ID-stage branch unit
  logic        branch_taken;
  logic [31:0] pc_branch;
  // Decode back-pressure
  logic        id_stall;
  // Instruction memory req/ack handshake
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // IF/ID pipeline register
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_misaligned;

  // Fetch unit side
  modport master (
    input  branch_taken, pc_branch, id_stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_instruction, if_pc, if_valid, if_misaligned
  );

  // Environment side: branch unit, decode stage and instruction memory
  modport slave (
    output branch_taken, pc_branch, id_stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_instruction, if_pc, if_valid, if_misaligned
  );
endinterface
`default_nettype wire

// File: rtl/elbeth_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : elbeth_fetch_unit
// Brief    : ELBETH instruction-fetch stage. Owns the PC, runs a req/ack
//            instruction-memory handshake, feeds the IF/ID register and
//            squashes wrong-path fetches after branch redirects.
// Revision : 1.0 - initial release
// ============================================================================
module elbeth_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  elbeth_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] C_PC_STEP = 32'd4;

  // Registered state
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_buf_mis;
  logic        r_redir_pend;
  logic [31:0] r_redir_pc;
  logic        r_mis_pend;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_if_valid;
  logic        r_if_mis;

  // Next-state values
  state_t      w_state_nx;
  logic [31:0] w_pc_nx;
  logic [31:0] w_buf_instr_nx;
  logic [31:0] w_buf_pc_nx;
  logic        w_buf_mis_nx;
  logic        w_redir_pend_nx;
  logic [31:0] w_redir_pc_nx;
  logic        w_mis_pend_nx;
  logic [31:0] w_if_instr_nx;
  logic [31:0] w_if_pc_nx;
  logic        w_if_valid_nx;
  logic        w_if_mis_nx;

  // Decoded helpers
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_target_mis;
  logic        w_if_free;
  logic [31:0] w_pc_inc;

  // A branch only counts when ID actually holds a real instruction it is consuming
  assign w_redirect   = bus.branch_taken & r_if_valid & ~bus.id_stall;
  assign w_target     = {bus.pc_branch[31:2], 2'b00};
  assign w_target_mis = |bus.pc_branch[1:0];
  assign w_if_free    = ~r_if_valid | ~bus.id_stall;
  assign w_pc_inc     = r_pc + C_PC_STEP;

  // Next-state, PC, skid-buffer and IF/ID update decode
  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_buf_instr_nx  = r_buf_instr;
    w_buf_pc_nx     = r_buf_pc;
    w_buf_mis_nx    = r_buf_mis;
    w_redir_pend_nx = r_redir_pend;
    w_redir_pc_nx   = r_redir_pc;
    w_mis_pend_nx   = r_mis_pend;
    w_if_instr_nx   = r_if_instr;
    w_if_pc_nx      = r_if_pc;
    w_if_valid_nx   = r_if_valid;
    w_if_mis_nx     = r_if_mis;

    // ID consumed the current entry; refilled below if something arrives
    if (!bus.id_stall) begin
      w_if_valid_nx = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        // Any ack here belongs to a request dropped by reset and is ignored
        w_state_nx = ST_REQ;
        if (w_redirect) begin
          w_pc_nx       = w_target;
          w_mis_pend_nx = w_target_mis;
        end
      end

      ST_REQ: begin
        if (bus.imem_ack) begin
          if (w_redirect) begin
            // The current-cycle target supersedes any pending one
            w_pc_nx         = w_target;
            w_mis_pend_nx   = w_target_mis;
            w_redir_pend_nx = 1'b0;
          end else if (r_redir_pend) begin
            // Squashed fetch finally returned; restart at the saved target
            w_pc_nx         = r_redir_pc;
            w_redir_pend_nx = 1'b0;
          end else if (w_if_free) begin
            w_if_instr_nx = bus.imem_rdata;
            w_if_pc_nx    = r_pc;
            w_if_valid_nx = 1'b1;
            w_if_mis_nx   = r_mis_pend;
            w_pc_nx       = w_pc_inc;
            w_mis_pend_nx = 1'b0;
          end else begin
            // ID is stalled on a valid entry: park the response
            w_buf_instr_nx = bus.imem_rdata;
            w_buf_pc_nx    = r_pc;
            w_buf_mis_nx   = r_mis_pend;
            w_pc_nx        = w_pc_inc;
            w_mis_pend_nx  = 1'b0;
            w_state_nx     = ST_HOLD;
          end
        end else if (w_redirect) begin
          // Request cannot be withdrawn; remember where to go once it returns
          w_redir_pend_nx = 1'b1;
          w_redir_pc_nx   = w_target;
          w_mis_pend_nx   = w_target_mis;
        end
      end

      ST_HOLD: begin
        if (!bus.id_stall) begin
          w_state_nx = ST_REQ;
          if (w_redirect) begin
            w_pc_nx       = w_target;
            w_mis_pend_nx = w_target_mis;
          end else begin
            w_if_instr_nx = r_buf_instr;
            w_if_pc_nx    = r_buf_pc;
            w_if_valid_nx = 1'b1;
            w_if_mis_nx   = r_buf_mis;
          end
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // Any accepted redirect squashes the instruction sitting in IF/ID
    if (w_redirect) begin
      w_if_valid_nx = 1'b0;
      w_if_instr_nx = NOP_INSTR;
      w_if_mis_nx   = 1'b0;
    end
  end

  // State, PC and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_buf_instr  <= NOP_INSTR;
      r_buf_pc     <= 32'h0;
      r_buf_mis    <= 1'b0;
      r_redir_pend <= 1'b0;
      r_redir_pc   <= 32'h0;
      r_mis_pend   <= 1'b0;
      r_if_instr   <= NOP_INSTR;
      r_if_pc      <= 32'h0;
      r_if_valid   <= 1'b0;
      r_if_mis     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_buf_instr  <= w_buf_instr_nx;
      r_buf_pc     <= w_buf_pc_nx;
      r_buf_mis    <= w_buf_mis_nx;
      r_redir_pend <= w_redir_pend_nx;
      r_redir_pc   <= w_redir_pc_nx;
      r_mis_pend   <= w_mis_pend_nx;
      r_if_instr   <= w_if_instr_nx;
      r_if_pc      <= w_if_pc_nx;
      r_if_valid   <= w_if_valid_nx;
      r_if_mis     <= w_if_mis_nx;
    end
  end

  // Outputs come straight from registers; imem_ack never reaches them combinationally
  assign bus.imem_req       = (r_state == ST_REQ);
  assign bus.imem_addr      = r_pc;
  assign bus.if_instruction = r_if_instr;
  assign bus.if_pc          = r_if_pc;
  assign bus.if_valid       = r_if_valid;
  assign bus.if_misaligned  = r_if_mis;

endmodule
`default_nettype wire

// File: tb/tb_elbeth_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_elbeth_fetch_unit
// Brief    : Directed self-checking bench for elbeth_fetch_unit. Memory model
//            returns the fetch address as the instruction word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elbeth_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Memory model controls
  int   lat;        // wait cycles before ack
  int   wait_cnt;
  logic mem_en;
  logic ack_force;

  elbeth_fetch_unit_if bus ();

  elbeth_fetch_unit #(
    .RESET_PC  (32'h0000_0100),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack after 'lat' wait cycles, data = address
  assign bus.imem_ack   = ack_force | (mem_en & bus.imem_req & (wait_cnt == lat));
  assign bus.imem_rdata = bus.imem_addr;

  // Wait-state counter for the outstanding request
  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.branch_taken = 1'b0; bus.pc_branch = 32'h0; bus.id_stall = 1'b0;
    lat = 0; mem_en = 1'b1; ack_force = 1'b0;
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h100) begin failures++; $display("FAIL reset_addr got=%h exp=00000100", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.if_instruction !== 32'h13) begin failures++; $display("FAIL reset_instr got=%h exp=00000013", bus.if_instruction); end
    checks++; if (bus.if_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", bus.if_pc); end
    checks++; if (bus.if_misaligned !== 1'b0) begin failures++; $display("FAIL reset_mis got=%b exp=0", bus.if_misaligned); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential;
    tick();  // 2nd cycle after reset release: first request
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin failures++; $display("FAIL seq_first_req req=%b addr=%h exp req=1 addr=00000100", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL seq_valid0 got=%b exp=0", bus.if_valid); end
    tick();
    checks++; if (bus.imem_addr !== 32'h104) begin failures++; $display("FAIL seq_addr1 got=%h exp=00000104", bus.imem_addr); end
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.if_instruction !== 32'h100) begin failures++; $display("FAIL seq_ifid0 valid=%b pc=%h instr=%h exp 1/00000100/00000100", bus.if_valid, bus.if_pc, bus.if_instruction); end
    tick();
    checks++; if (bus.imem_addr !== 32'h108 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL seq_addr2 got=%h req=%b exp=00000108 req=1", bus.imem_addr, bus.imem_req); end
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h104 || bus.if_instruction !== 32'h104) begin failures++; $display("FAIL seq_ifid1 valid=%b pc=%h instr=%h exp 1/00000104/00000104", bus.if_valid, bus.if_pc, bus.if_instruction); end
  endtask

  task automatic test_redirect;
    bus.branch_taken = 1'b1; bus.pc_branch = 32'h200;
    tick();
    bus.branch_taken = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.if_instruction !== 32'h13) begin failures++; $display("FAIL redir_flush valid=%b instr=%h exp 0/00000013", bus.if_valid, bus.if_instruction); end
    checks++; if (bus.imem_addr !== 32'h200) begin failures++; $display("FAIL redir_addr got=%h exp=00000200", bus.imem_addr); end
    tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200 || bus.if_instruction !== 32'h200) begin failures++; $display("FAIL redir_target valid=%b pc=%h instr=%h exp 1/00000200/00000200", bus.if_valid, bus.if_pc, bus.if_instruction); end
  endtask

  task automatic test_wait_redirect;
    bus.branch_taken = 1'b1; bus.pc_branch = 32'h108;
    tick();
    bus.branch_taken = 1'b0; lat = 3;
    for (int i = 0; i < 10 && bus.if_valid !== 1'b1; i++) tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h108 || bus.imem_addr !== 32'h10C) begin failures++; $display("FAIL wait_setup valid=%b pc=%h addr=%h exp 1/00000108/0000010c", bus.if_valid, bus.if_pc, bus.imem_addr); end
    bus.id_stall = 1'b1;
    tick();
    bus.id_stall = 1'b0; bus.branch_taken = 1'b1; bus.pc_branch = 32'h400;
    tick();
    bus.branch_taken = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10C || bus.if_valid !== 1'b0) begin failures++; $display("FAIL wait_hold1 req=%b addr=%h valid=%b exp 1/0000010c/0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10C) begin failures++; $display("FAIL wait_hold2 req=%b addr=%h exp 1/0000010c", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.imem_addr !== 32'h400 || bus.if_valid !== 1'b0) begin failures++; $display("FAIL wait_newreq addr=%h valid=%b exp 00000400/0", bus.imem_addr, bus.if_valid); end
    for (int i = 0; i < 10 && bus.if_valid !== 1'b1; i++) tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h400 || bus.if_instruction !== 32'h400) begin failures++; $display("FAIL wait_target valid=%b pc=%h instr=%h exp 1/00000400/00000400", bus.if_valid, bus.if_pc, bus.if_instruction); end
    lat = 0;
  endtask

  task automatic test_stall;
    bus.id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h400 || bus.if_instruction !== 32'h400) begin failures++; $display("FAIL stall_hold%0d req=%b valid=%b pc=%h instr=%h exp 0/1/00000400/00000400", i, bus.imem_req, bus.if_valid, bus.if_pc, bus.if_instruction); end
    end
    bus.id_stall = 1'b0;
    tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h404 || bus.if_instruction !== 32'h404) begin failures++; $display("FAIL stall_release valid=%b pc=%h instr=%h exp 1/00000404/00000404", bus.if_valid, bus.if_pc, bus.if_instruction); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h408) begin failures++; $display("FAIL stall_resume req=%b addr=%h exp 1/00000408", bus.imem_req, bus.imem_addr); end
    tick();
    checks++; if (bus.if_pc !== 32'h408 || bus.imem_addr !== 32'h40C) begin failures++; $display("FAIL stall_next pc=%h addr=%h exp 00000408/0000040c", bus.if_pc, bus.imem_addr); end
  endtask

  task automatic test_misaligned;
    bus.branch_taken = 1'b1; bus.pc_branch = 32'h302;
    tick();
    bus.branch_taken = 1'b0;
    checks++; if (bus.imem_addr !== 32'h300) begin failures++; $display("FAIL mis_addr got=%h exp=00000300", bus.imem_addr); end
    tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h300 || bus.if_misaligned !== 1'b1) begin failures++; $display("FAIL mis_first valid=%b pc=%h mis=%b exp 1/00000300/1", bus.if_valid, bus.if_pc, bus.if_misaligned); end
    tick();
    checks++; if (bus.if_pc !== 32'h304 || bus.if_misaligned !== 1'b0) begin failures++; $display("FAIL mis_second pc=%h mis=%b exp 00000304/0", bus.if_pc, bus.if_misaligned); end
  endtask

  task automatic test_wrap;
    bus.branch_taken = 1'b1; bus.pc_branch = 32'hFFFF_FFFC;
    tick();
    bus.branch_taken = 1'b0;
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", bus.imem_addr); end
    tick();
    checks++; if (bus.if_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_inc pc=%h addr=%h exp fffffffc/00000000", bus.if_pc, bus.imem_addr); end
    tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin failures++; $display("FAIL wrap_zero valid=%b pc=%h exp 1/00000000", bus.if_valid, bus.if_pc); end
  endtask

  task automatic test_branch_ignored;
    bus.id_stall = 1'b1; bus.branch_taken = 1'b1; bus.pc_branch = 32'h500;
    tick();
    bus.branch_taken = 1'b0; bus.id_stall = 1'b0;
    checks++; if (bus.imem_req !== 1'b0 || bus.if_pc !== 32'h0) begin failures++; $display("FAIL ign_hold req=%b pc=%h exp 0/00000000", bus.imem_req, bus.if_pc); end
    tick();
    checks++; if (bus.if_pc !== 32'h4 || bus.imem_addr !== 32'h8) begin failures++; $display("FAIL ign_continue pc=%h addr=%h exp 00000004/00000008", bus.if_pc, bus.imem_addr); end
  endtask

  task automatic test_reset_mid;
    mem_en = 1'b0;
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin failures++; $display("FAIL rmid_pending req=%b addr=%h exp 1/00000008", bus.imem_req, bus.imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h100 || bus.if_valid !== 1'b0 || bus.if_instruction !== 32'h13 || bus.if_pc !== 32'h0 || bus.if_misaligned !== 1'b0) begin failures++; $display("FAIL rmid_async req=%b addr=%h valid=%b instr=%h pc=%h mis=%b exp 0/00000100/0/00000013/00000000/0", bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_instruction, bus.if_pc, bus.if_misaligned); end
    tick();
    rst_n = 1'b1; ack_force = 1'b1;  // late ack lands while in IDLE
    tick();
    ack_force = 1'b0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.if_valid !== 1'b0) begin failures++; $display("FAIL rmid_restart req=%b addr=%h valid=%b exp 1/00000100/0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    mem_en = 1'b1;
    tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h100 || bus.imem_addr !== 32'h104) begin failures++; $display("FAIL rmid_first valid=%b pc=%h addr=%h exp 1/00000100/00000104", bus.if_valid, bus.if_pc, bus.imem_addr); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_sequential();
    test_redirect();
    test_wait_redirect();
    test_stall();
    test_misaligned();
    test_wrap();
    test_branch_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
